// File: rtl/wb_arb_pkg.sv
// Shared types for the Wishbone main-memory arbiter: FSM states and
// the burst-type encodings seen on the cti/bte lines.
package wb_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;

   typedef enum logic [2:0] {
      CLASSIC = 3'b000,
      INCR    = 3'b010,
      EOB     = 3'b111
   } cti_e;

   typedef enum logic [1:0] {
      LINEAR = 2'b00
   } bte_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority picker: grants the first requester
// strictly after the one-hot last_i position, wrapping around.
module rr_arbiter #(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0] req_i,
   input  logic [N-1:0] last_i,
   output logic [N-1:0] grant_o
);

   localparam logic [N-1:0] ONE = N'(1);

   logic [N-1:0] higher;
   logic [N-1:0] masked;
   logic [N-1:0] pick_src;

   always_comb begin
      // Bits strictly above last_i; if none of them request, wrap to bit 0 upward.
      higher   = ~(last_i | (last_i - ONE));
      masked   = req_i & higher;
      pick_src = (masked != '0) ? masked : req_i;
      grant_o  = pick_src & (~pick_src + ONE);
   end

endmodule

// File: rtl/wb_mem_arbiter.sv
// Round-robin Wishbone B3 arbiter sharing one memory slave among masters;
// grants are held until cyc drops and a watchdog aborts unanswered strobes.
module wb_mem_arbiter
   import wb_arb_pkg::*;
#(
   parameter int unsigned NUM_MASTERS    = 4,
   parameter int unsigned AW             = 32,
   parameter int unsigned DW             = 32,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                        wb_clk_i,
   input  logic                        wb_rst_ni,
   input  logic [NUM_MASTERS*AW-1:0]   m_adr_i,
   input  logic [NUM_MASTERS*DW-1:0]   m_dat_i,
   input  logic [NUM_MASTERS*DW/8-1:0] m_sel_i,
   input  logic [NUM_MASTERS-1:0]      m_we_i,
   input  logic [NUM_MASTERS-1:0]      m_cyc_i,
   input  logic [NUM_MASTERS-1:0]      m_stb_i,
   input  logic [NUM_MASTERS*3-1:0]    m_cti_i,
   input  logic [NUM_MASTERS*2-1:0]    m_bte_i,
   output logic [DW-1:0]               m_dat_o,
   output logic [NUM_MASTERS-1:0]      m_ack_o,
   output logic [NUM_MASTERS-1:0]      m_err_o,
   output logic [NUM_MASTERS-1:0]      m_rty_o,
   output logic [AW-1:0]               s_adr_o,
   output logic [DW-1:0]               s_dat_o,
   output logic [DW/8-1:0]             s_sel_o,
   output logic                        s_we_o,
   output logic                        s_cyc_o,
   output logic                        s_stb_o,
   output logic [2:0]                  s_cti_o,
   output logic [1:0]                  s_bte_o,
   input  logic [DW-1:0]               s_dat_i,
   input  logic                        s_ack_i,
   input  logic                        s_err_i,
   input  logic                        s_rty_i,
   output logic [NUM_MASTERS-1:0]      grant_o,
   output logic                        timeout_o
);

   localparam int unsigned SW = DW / 8;
   localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);
   localparam logic WDOG_EN = (TIMEOUT_CYCLES != 0);
   localparam logic [NUM_MASTERS-1:0] FIRST    = NUM_MASTERS'(1);
   localparam logic [NUM_MASTERS-1:0] LAST_RST = FIRST << (NUM_MASTERS - 1);

   arb_state_e             state_q, state_d;
   logic [NUM_MASTERS-1:0] grant_q, grant_d;
   logic [NUM_MASTERS-1:0] last_q, last_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [NUM_MASTERS-1:0] pick;

   logic [NUM_MASTERS-1:0] sel_oh;
   logic [AW-1:0]          adr_mux;
   logic [DW-1:0]          dat_mux;
   logic [SW-1:0]          sel_mux;
   logic                   we_mux;
   logic [2:0]             cti_mux;
   logic [1:0]             bte_mux;

   logic busy;
   logic g_cyc;
   logic g_stb;
   logic resp;
   logic abort;

   rr_arbiter #(
      .N (NUM_MASTERS)
   ) u_rr (
      .req_i   (m_cyc_i),
      .last_i  (last_q),
      .grant_o (pick)
   );

   // Request-side mux; with no grant the slave sees master 0's address/data.
   always_comb begin
      sel_oh  = (grant_q == '0) ? FIRST : grant_q;
      adr_mux = m_adr_i[AW-1:0];
      dat_mux = m_dat_i[DW-1:0];
      sel_mux = m_sel_i[SW-1:0];
      we_mux  = m_we_i[0];
      cti_mux = m_cti_i[2:0];
      bte_mux = m_bte_i[1:0];
      for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
         if (sel_oh[k]) begin
            adr_mux = m_adr_i[k*AW +: AW];
            dat_mux = m_dat_i[k*DW +: DW];
            sel_mux = m_sel_i[k*SW +: SW];
            we_mux  = m_we_i[k];
            cti_mux = m_cti_i[k*3 +: 3];
            bte_mux = m_bte_i[k*2 +: 2];
         end
      end
   end

   always_comb begin
      busy  = (state_q == BUSY);
      g_cyc = |(m_cyc_i & grant_q);
      g_stb = |(m_stb_i & grant_q);
      resp  = s_ack_i | s_err_i | s_rty_i;
      abort = WDOG_EN & busy & g_stb & ~resp & (cnt_q == CNT_MAX);
   end

   always_comb begin
      s_adr_o   = adr_mux;
      s_dat_o   = dat_mux;
      s_sel_o   = sel_mux;
      s_we_o    = we_mux;
      s_cti_o   = busy ? cti_mux : CLASSIC;
      s_bte_o   = busy ? bte_mux : LINEAR;
      s_cyc_o   = busy & g_cyc;
      s_stb_o   = busy & g_stb & ~abort;
      m_dat_o   = s_dat_i;
      m_ack_o   = grant_q & {NUM_MASTERS{s_ack_i & ~abort}};
      m_err_o   = grant_q & {NUM_MASTERS{s_err_i | abort}};
      m_rty_o   = grant_q & {NUM_MASTERS{s_rty_i}};
      grant_o   = grant_q;
      timeout_o = abort;
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      unique case (state_q)
         IDLE: begin
            if (m_cyc_i != '0) begin
               grant_d = pick;
               last_d  = pick;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (!g_cyc) begin
               grant_d = '0;
               state_d = IDLE;
            end
         end
         default: begin
            grant_d = '0;
            state_d = IDLE;
         end
      endcase
   end

   // Watchdog holds its count while the granted master idles stb with cyc high.
   always_comb begin
      cnt_d = cnt_q;
      if (!busy || resp || abort) begin
         cnt_d = '0;
      end else if (g_stb) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= LAST_RST;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed bench for wb_mem_arbiter: four masters, watchdog set to 16 cycles.
module tb_wb_mem_arbiter;
   import wb_arb_pkg::*;

   logic          clk;
   logic          rst_n;
   logic [127:0]  m_adr;
   logic [127:0]  m_dat;
   logic [15:0]   m_sel;
   logic [3:0]    m_we;
   logic [3:0]    m_cyc;
   logic [3:0]    m_stb;
   logic [11:0]   m_cti;
   logic [7:0]    m_bte;
   logic [31:0]   m_dat_o;
   logic [3:0]    m_ack_o;
   logic [3:0]    m_err_o;
   logic [3:0]    m_rty_o;
   logic [31:0]   s_adr_o;
   logic [31:0]   s_dat_o;
   logic [3:0]    s_sel_o;
   logic          s_we_o;
   logic          s_cyc_o;
   logic          s_stb_o;
   logic [2:0]    s_cti_o;
   logic [1:0]    s_bte_o;
   logic [31:0]   s_dat_i;
   logic          s_ack_i;
   logic          s_err_i;
   logic          s_rty_i;
   logic [3:0]    grant_o;
   logic          timeout_o;

   int pass_cnt  = 0;
   int total_cnt = 0;

   wb_mem_arbiter #(
      .NUM_MASTERS    (4),
      .AW             (32),
      .DW             (32),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .wb_clk_i  (clk),
      .wb_rst_ni (rst_n),
      .m_adr_i   (m_adr),
      .m_dat_i   (m_dat),
      .m_sel_i   (m_sel),
      .m_we_i    (m_we),
      .m_cyc_i   (m_cyc),
      .m_stb_i   (m_stb),
      .m_cti_i   (m_cti),
      .m_bte_i   (m_bte),
      .m_dat_o   (m_dat_o),
      .m_ack_o   (m_ack_o),
      .m_err_o   (m_err_o),
      .m_rty_o   (m_rty_o),
      .s_adr_o   (s_adr_o),
      .s_dat_o   (s_dat_o),
      .s_sel_o   (s_sel_o),
      .s_we_o    (s_we_o),
      .s_cyc_o   (s_cyc_o),
      .s_stb_o   (s_stb_o),
      .s_cti_o   (s_cti_o),
      .s_bte_o   (s_bte_o),
      .s_dat_i   (s_dat_i),
      .s_ack_i   (s_ack_i),
      .s_err_i   (s_err_i),
      .s_rty_i   (s_rty_i),
      .grant_o   (grant_o),
      .timeout_o (timeout_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      m_adr   = '0;
      m_dat   = '0;
      m_sel   = '1;
      m_we    = '0;
      m_cyc   = '0;
      m_stb   = '0;
      m_cti   = '0;
      m_bte   = '0;
      s_dat_i = '0;
      s_ack_i = 1'b0;
      s_err_i = 1'b0;
      s_rty_i = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 1'b0;
      m_cyc = 4'hF;
      m_stb = 4'hF;
      tick();
      #1;
      total_cnt++;
      if ({s_cyc_o, s_stb_o} !== 2'b00) $display("FAIL reset_strobes: got %b exp 00", {s_cyc_o, s_stb_o});
      else pass_cnt++;
      total_cnt++;
      if (grant_o !== 4'b0000) $display("FAIL reset_grant: got %b exp 0000", grant_o);
      else pass_cnt++;
      total_cnt++;
      if ({m_ack_o, m_err_o, m_rty_o, timeout_o} !== 13'b0) $display("FAIL reset_resp: got %b exp 0", {m_ack_o, m_err_o, m_rty_o, timeout_o});
      else pass_cnt++;
      clear_inputs();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single_read();
      do_reset();
      m_cyc[1] = 1'b1;
      m_stb[1] = 1'b1;
      m_adr[32 +: 32] = 32'h0000_0100;
      #1;
      total_cnt++;
      if ({grant_o, s_cyc_o} !== 5'b0) $display("FAIL single_cycle0: got grant %b cyc %b exp 0000 0", grant_o, s_cyc_o);
      else pass_cnt++;
      tick();
      total_cnt++;
      if ({s_cyc_o, s_stb_o} !== 2'b11) $display("FAIL single_strobes: got %b exp 11", {s_cyc_o, s_stb_o});
      else pass_cnt++;
      total_cnt++;
      if (grant_o !== 4'b0010) $display("FAIL single_grant: got %b exp 0010", grant_o);
      else pass_cnt++;
      total_cnt++;
      if (s_adr_o !== 32'h0000_0100) $display("FAIL single_adr: got %h exp 00000100", s_adr_o);
      else pass_cnt++;
      tick();
      tick();
      s_ack_i = 1'b1;
      s_dat_i = 32'hDEAD_BEEF;
      #1;
      total_cnt++;
      if (m_ack_o !== 4'b0010) $display("FAIL single_ack: got %b exp 0010", m_ack_o);
      else pass_cnt++;
      total_cnt++;
      if (m_dat_o !== 32'hDEAD_BEEF) $display("FAIL single_data: got %h exp deadbeef", m_dat_o);
      else pass_cnt++;
      tick();
      s_ack_i  = 1'b0;
      m_cyc[1] = 1'b0;
      m_stb[1] = 1'b0;
      #1;
      total_cnt++;
      if ({s_cyc_o, grant_o} !== 5'b0_0010) $display("FAIL single_release: got cyc %b grant %b exp 0 0010", s_cyc_o, grant_o);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (grant_o !== 4'b0000) $display("FAIL single_idle: got %b exp 0000", grant_o);
      else pass_cnt++;
   endtask

   task automatic test_two_masters();
      do_reset();
      m_cyc = 4'b0101;
      m_stb = 4'b0101;
      m_dat[64 +: 32] = 32'hCAFE_F00D;
      m_we[2] = 1'b1;
      tick();
      total_cnt++;
      if (grant_o !== 4'b0001) $display("FAIL two_first: got %b exp 0001", grant_o);
      else pass_cnt++;
      s_ack_i = 1'b1;
      tick();
      s_ack_i  = 1'b0;
      m_cyc[0] = 1'b0;
      m_stb[0] = 1'b0;
      tick();
      total_cnt++;
      if ({grant_o, s_cyc_o} !== 5'b0) $display("FAIL two_gap: got grant %b cyc %b exp 0000 0", grant_o, s_cyc_o);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (grant_o !== 4'b0100) $display("FAIL two_second: got %b exp 0100", grant_o);
      else pass_cnt++;
      total_cnt++;
      if ({s_we_o, s_dat_o} !== {1'b1, 32'hCAFE_F00D}) $display("FAIL two_wdata: got we %b dat %h exp 1 cafef00d", s_we_o, s_dat_o);
      else pass_cnt++;
      s_rty_i = 1'b1;
      #1;
      total_cnt++;
      if ({m_rty_o, m_ack_o} !== 8'b0100_0000) $display("FAIL two_retry: got rty %b ack %b exp 0100 0000", m_rty_o, m_ack_o);
      else pass_cnt++;
      tick();
      s_rty_i = 1'b0;
      m_cyc   = '0;
      m_stb   = '0;
      tick();
   endtask

   task automatic test_round_robin();
      logic [3:0] exp;
      do_reset();
      m_cyc = 4'hF;
      m_stb = 4'hF;
      for (int i = 0; i < 6; i++) begin
         exp = 4'b0001 << (i % 4);
         tick();
         total_cnt++;
         if (grant_o !== exp) $display("FAIL rr_grant_%0d: got %b exp %b", i, grant_o, exp);
         else pass_cnt++;
         s_ack_i = 1'b1;
         #1;
         total_cnt++;
         if (m_ack_o !== exp) $display("FAIL rr_ack_%0d: got %b exp %b", i, m_ack_o, exp);
         else pass_cnt++;
         tick();
         s_ack_i = 1'b0;
         m_cyc   = m_cyc & ~exp;
         m_stb   = m_stb & ~exp;
         tick();
         m_cyc = 4'hF;
         m_stb = 4'hF;
      end
      clear_inputs();
      tick();
      tick();
   endtask

   task automatic test_back_to_back_burst();
      logic [2:0] cti;
      do_reset();
      m_cyc = 4'b1010;
      m_stb = 4'b1010;
      m_cti[3 +: 3] = INCR;
      tick();
      for (int b = 0; b < 4; b++) begin
         cti = (b == 3) ? EOB : INCR;
         m_cti[3 +: 3] = cti;
         s_ack_i = 1'b1;
         #1;
         total_cnt++;
         if ({grant_o, m_ack_o} !== 8'b0010_0010) $display("FAIL burst_beat_%0d: got grant %b ack %b exp 0010 0010", b, grant_o, m_ack_o);
         else pass_cnt++;
         total_cnt++;
         if (s_cti_o !== cti) $display("FAIL burst_cti_%0d: got %b exp %b", b, s_cti_o, cti);
         else pass_cnt++;
         tick();
      end
      s_ack_i  = 1'b0;
      m_cyc[1] = 1'b0;
      m_stb[1] = 1'b0;
      m_cti[3 +: 3] = CLASSIC;
      #1;
      total_cnt++;
      if ({s_cyc_o, grant_o} !== 5'b0_0010) $display("FAIL burst_release: got cyc %b grant %b exp 0 0010", s_cyc_o, grant_o);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (grant_o !== 4'b0000) $display("FAIL burst_idle: got %b exp 0000", grant_o);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (grant_o !== 4'b1000) $display("FAIL burst_next: got %b exp 1000", grant_o);
      else pass_cnt++;
      clear_inputs();
      tick();
      tick();
   endtask

   task automatic test_timeout();
      do_reset();
      m_cyc[2] = 1'b1;
      m_stb[2] = 1'b1;
      for (int c = 1; c <= 15; c++) begin
         tick();
         total_cnt++;
         if ({timeout_o, m_err_o, s_stb_o} !== 6'b0_0000_1) $display("FAIL wdog_wait_%0d: got to %b err %b stb %b exp 0 0000 1", c, timeout_o, m_err_o, s_stb_o);
         else pass_cnt++;
      end
      tick();
      total_cnt++;
      if ({timeout_o, m_err_o} !== 5'b1_0100) $display("FAIL wdog_abort: got to %b err %b exp 1 0100", timeout_o, m_err_o);
      else pass_cnt++;
      total_cnt++;
      if ({s_cyc_o, s_stb_o} !== 2'b10) $display("FAIL wdog_stb: got %b exp 10", {s_cyc_o, s_stb_o});
      else pass_cnt++;
      tick();
      total_cnt++;
      if ({timeout_o, m_err_o, s_stb_o, grant_o} !== 10'b0_0000_1_0100) $display("FAIL wdog_after: got to %b err %b stb %b grant %b exp 0 0000 1 0100", timeout_o, m_err_o, s_stb_o, grant_o);
      else pass_cnt++;
      clear_inputs();
      tick();
      tick();
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      m_cyc[0] = 1'b1;
      m_stb[0] = 1'b1;
      m_cti[2:0] = INCR;
      tick();
      s_ack_i = 1'b1;
      tick();
      #1;
      rst_n = 1'b0;
      #1;
      total_cnt++;
      if ({s_cyc_o, s_stb_o, grant_o} !== 6'b0) $display("FAIL rstmid_drop: got cyc %b stb %b grant %b exp 0 0 0000", s_cyc_o, s_stb_o, grant_o);
      else pass_cnt++;
      s_ack_i = 1'b0;
      m_cti   = '0;
      m_cyc   = 4'b0011;
      m_stb   = 4'b0011;
      tick();
      rst_n = 1'b1;
      tick();
      total_cnt++;
      if (grant_o !== 4'b0001) $display("FAIL rstmid_regrant: got %b exp 0001", grant_o);
      else pass_cnt++;
      clear_inputs();
      tick();
      tick();
   endtask

   initial begin
      rst_n = 1'b0;
      clear_inputs();
      test_reset();
      test_single_read();
      test_two_masters();
      test_round_robin();
      test_back_to_back_burst();
      test_timeout();
      test_reset_mid_burst();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
